// File: rtl/spi_deser_pkg.sv
// Shared types, default parameters and width helper for the SPI stream deserializer.
package spi_deser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    STREAM
  } rx_state_t;

  localparam int unsigned DEF_WORD_W          = 24;
  localparam int unsigned DEF_FIFO_DEPTH      = 8;
  localparam int unsigned DEF_WORDS_PER_FRAME = 1200;

  // Bits needed to hold any value 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dff_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module dff_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO with first-word-fall-through output; DEPTH must be a power of 2.
module spi_rx_fifo
  import spi_deser_pkg::*;
#(
  parameter int unsigned W     = DEF_WORD_W,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_w(DEPTH)-1:0]    level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = cnt_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A write into a full FIFO is accepted when a read frees the head slot in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_ok && !rd_ok)      level_d = level_q + LVL_W'(1);
      else if (!wr_ok && rd_ok) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_stream_deserializer.sv
// SPI serial-video receiver: synchronises pins, assembles MSB-first words into a FIFO per frame.
// Optional debug taps (debug_word, debug_bit_cnt) are built when SPI_DESER_DEBUG_TAP_EN is defined.
module spi_stream_deserializer
  import spi_deser_pkg::*;
#(
  parameter int unsigned WORD_W          = DEF_WORD_W,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
  input  logic                           CLK_40,
  input  logic                           reset,
  input  logic                           init,
  input  logic                           vid_start,
  input  logic                           SPI_clk_CDC,
  input  logic                           MISO_CDC,
  output logic                           chip_select,
  output logic [WORD_W-1:0]              word_data,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [cnt_w(FIFO_DEPTH)-1:0]   fifo_level,
  output logic                           overflow,
  output logic                           frame_done,
  output logic                           busy
`ifdef SPI_DESER_DEBUG_TAP_EN
  ,
  output logic [WORD_W-1:0]              debug_word,
  output logic [cnt_w(WORD_W)-1:0]       debug_bit_cnt
`endif
);

  localparam int unsigned BIT_W = cnt_w(WORD_W);
  localparam int unsigned FRM_W = cnt_w(WORDS_PER_FRAME);

  rx_state_t         state_q, state_d;
  // Only WORD_W-1 bits are held; the final bit is appended straight into the pushed word.
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              spi_clk_prev_q, spi_clk_prev_d;

  logic              spi_clk_sync;
  logic              miso_sync;
  logic              rise;
  logic [WORD_W-1:0] word_full;
  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;

  dff_sync2 u_sync_clk (
    .clk (CLK_40),
    .rst (reset),
    .d   (SPI_clk_CDC),
    .q   (spi_clk_sync)
  );

  dff_sync2 u_sync_miso (
    .clk (CLK_40),
    .rst (reset),
    .d   (MISO_CDC),
    .q   (miso_sync)
  );

  assign spi_clk_prev_d = spi_clk_sync;
  assign rise           = spi_clk_sync & ~spi_clk_prev_q;
  assign word_full      = {shift_q, miso_sync};
  assign pop            = word_valid & word_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;
    if (init) begin
      state_d     = ARMED;
      shift_d     = '0;
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      overflow_d  = 1'b0;
      flush       = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          if (vid_start) state_d = STREAM;
        end
        STREAM: begin
          if (rise) begin
            shift_d = word_full[WORD_W-2:0];
            if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
              bit_cnt_d = '0;
              push      = 1'b1;
              if (fifo_full && !pop) overflow_d = 1'b1;
              if (frame_cnt_q == FRM_W'(WORDS_PER_FRAME - 1)) begin
                frame_cnt_d  = '0;
                frame_done_d = 1'b1;
                state_d      = ARMED;
              end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      overflow_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      spi_clk_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      overflow_q     <= overflow_d;
      frame_done_q   <= frame_done_d;
      spi_clk_prev_q <= spi_clk_prev_d;
    end
  end

  spi_rx_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_40),
    .rst     (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (word_full),
    .rd_en   (word_ready),
    .rd_data (word_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign word_valid  = ~fifo_empty;
  assign chip_select = (state_q != STREAM);
  assign busy        = (state_q != IDLE);
  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;

`ifdef SPI_DESER_DEBUG_TAP_EN
  logic [WORD_W-1:0] debug_word_q, debug_word_d;

  always_comb begin
    debug_word_d = debug_word_q;
    if (push) debug_word_d = word_full;
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) debug_word_q <= '0;
    else       debug_word_q <= debug_word_d;
  end

  assign debug_word    = debug_word_q;
  assign debug_bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_spi_stream_deserializer.sv
// Directed/randomised bench for spi_stream_deserializer with a queue-based reference model.
module tb_spi_stream_deserializer;

  localparam int unsigned W   = 24;
  localparam int unsigned D   = 8;
  localparam int unsigned WPF = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          vid_start;
  logic          sck;
  logic          miso;
  logic          word_ready;
  logic          chip_select;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic [3:0]    fifo_level;
  logic          overflow;
  logic          frame_done;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] popped[$];
  int           valid_cycles;
  int           fd_cnt;

  logic         snap_valid, snap_fd, snap_cs, snap_busy;
  logic [W-1:0] snap_data;

  // Reference model: words in the FIFO, sticky overflow, frame position, streaming flag.
  logic [W-1:0] model_q[$];
  logic         model_ovf;
  int           model_pos;
  bit           model_armed;
  bit           model_streaming;

  logic [W-1:0] words[10];

  spi_stream_deserializer #(
    .WORD_W          (W),
    .FIFO_DEPTH      (D),
    .WORDS_PER_FRAME (WPF)
  ) dut (
    .CLK_40      (clk),
    .reset       (reset),
    .init        (init),
    .vid_start   (vid_start),
    .SPI_clk_CDC (sck),
    .MISO_CDC    (miso),
    .chip_select (chip_select),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample before the edge (pops happen on it), then step past the edge.
  task automatic tick();
    @(negedge clk);
    if (word_valid && word_ready) popped.push_back(word_data);
    if (word_valid) valid_cycles++;
    if (frame_done) fd_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // 4 cycles low + 4 high = 5 MHz. Third tick after the rising pin edge lands just past the push.
  task automatic send_bit(input logic b, input bit pop_at_push);
    miso = b;
    sck  = 1'b0;
    ticks(4);
    sck = 1'b1;
    tick();
    tick();
    if (pop_at_push) word_ready = 1'b1;
    tick();
    if (pop_at_push) word_ready = 1'b0;
    snap_valid = word_valid;
    snap_data  = word_data;
    snap_fd    = frame_done;
    snap_cs    = chip_select;
    snap_busy  = busy;
    tick();
  endtask

  task automatic model_word(input logic [W-1:0] w, input bit coincident_pop);
    if (!model_streaming) return;
    if (coincident_pop) void'(model_q.pop_front());
    if (model_q.size() < D) model_q.push_back(w);
    else model_ovf = 1'b1;
    model_pos++;
    if (model_pos == WPF) begin
      model_pos       = 0;
      model_streaming = 0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit pop_last);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], (i == 0) && pop_last);
    model_word(w, pop_last);
  endtask

  task automatic send_partial(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[W-1-i], 1'b0);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    model_q.delete();
    model_ovf       = 1'b0;
    model_pos       = 0;
    model_armed     = 1;
    model_streaming = 0;
  endtask

  task automatic pulse_vid();
    vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    if (model_armed && !model_streaming) model_streaming = 1;
  endtask

  task automatic compare_pops(input string tag);
    logic [W-1:0] got, exp;
    while (popped.size() > 0) begin
      got = popped.pop_front();
      exp = (model_q.size() > 0) ? model_q.pop_front() : 'x;
      check(tag, 64'(got), 64'(exp));
    end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; vid_start = 1'b0;
    sck = 1'b0; miso = 1'b0; word_ready = 1'b0;
    valid_cycles = 0; fd_cnt = 0;
    model_ovf = 1'b0; model_pos = 0; model_armed = 0; model_streaming = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    check("rst_cs",    64'(chip_select), 64'd1);
    check("rst_valid", 64'(word_valid),  64'd0);
    check("rst_data",  64'(word_data),   64'd0);
    check("rst_level", 64'(fifo_level),  64'd0);
    check("rst_ovf",   64'(overflow),    64'd0);
    check("rst_fd",    64'(frame_done),  64'd0);
    check("rst_busy",  64'(busy),        64'd0);

    pulse_vid();
    check("vid_in_idle_busy", 64'(busy), 64'd0);

    pulse_init();
    check("armed_busy", 64'(busy), 64'd1);
    check("armed_cs",   64'(chip_select), 64'd1);
    pulse_vid();
    check("stream_cs", 64'(chip_select), 64'd0);

    // Single word with a ready consumer.
    word_ready   = 1'b1;
    valid_cycles = 0;
    send_word(24'hA5C3F0, 1'b0);
    check("w1_snap_valid", 64'(snap_valid), 64'd1);
    check("w1_snap_data",  64'(snap_data),  64'hA5C3F0);
    ticks(4);
    check("w1_valid_cycles", 64'(valid_cycles), 64'd1);
    check("w1_pop_count",    64'(popped.size()), 64'd1);
    compare_pops("w1_pop");
    check("w1_cs_still_low", 64'(chip_select), 64'd0);

    // Full frame of WPF words, then a burst that must be ignored.
    pulse_init();
    pulse_vid();
    fd_cnt = 0;
    send_word(24'h000001, 1'b0);
    send_word(24'h000002, 1'b0);
    send_word(24'h000003, 1'b0);
    check("frame_snap_fd",   64'(snap_fd),   64'd1);
    check("frame_snap_cs",   64'(snap_cs),   64'd1);
    check("frame_snap_busy", 64'(snap_busy), 64'd1);
    ticks(4);
    check("frame_fd_count", 64'(fd_cnt), 64'd1);
    compare_pops("frame_pop");
    valid_cycles = 0;
    send_word(24'hFFFFFF, 1'b0);
    ticks(4);
    check("ignored_valid_cycles", 64'(valid_cycles), 64'd0);
    check("ignored_level",        64'(fifo_level), 64'd0);
    check("ignored_cs",           64'(chip_select), 64'd1);
    check("ignored_fd_count",     64'(fd_cnt), 64'd1);

    // Overflow: 9 random words, no consumer.
    word_ready = 1'b0;
    pulse_init();
    for (int i = 0; i < 9; i++) begin
      words[i] = W'($urandom);
      if (i % WPF == 0) pulse_vid();
      send_word(words[i], 1'b0);
    end
    check("ovf_level", 64'(fifo_level), 64'(model_q.size()));
    check("ovf_flag",  64'(overflow),   64'(model_ovf));
    check("ovf_level_full", 64'(fifo_level), 64'd8);
    word_ready = 1'b1;
    ticks(12);
    word_ready = 1'b0;
    check("ovf_drain_count", 64'(popped.size()), 64'd8);
    check("ovf_drain_first", 64'(popped[0]), 64'(words[0]));
    compare_pops("ovf_drain");
    check("ovf_empty_level", 64'(fifo_level), 64'd0);

    // Full FIFO with a pop coincident with the 9th word's completion.
    pulse_init();
    for (int i = 0; i < 9; i++) begin
      words[i] = W'($urandom);
      if (i % WPF == 0) pulse_vid();
      send_word(words[i], i == 8);
    end
    check("coinc_ovf",   64'(overflow),   64'd0);
    check("coinc_level", 64'(fifo_level), 64'd8);
    check("coinc_pop0",  64'(popped[0]),  64'(words[0]));
    void'(popped.pop_front());
    word_ready = 1'b1;
    ticks(12);
    word_ready = 1'b0;
    check("coinc_drain_count", 64'(popped.size()), 64'd8);
    check("coinc_last",        64'(popped[7]), 64'(words[8]));
    compare_pops("coinc_drain");

    // init after a partial word.
    pulse_init();
    pulse_vid();
    words[0] = W'($urandom);
    send_partial(words[0], 10);
    pulse_init();
    check("abort_level", 64'(fifo_level), 64'd0);
    check("abort_valid", 64'(word_valid), 64'd0);
    check("abort_cs",    64'(chip_select), 64'd1);
    pulse_vid();
    words[1] = W'($urandom);
    send_word(words[1], 1'b0);
    check("abort_next_level", 64'(fifo_level), 64'd1);
    check("abort_next_data",  64'(word_data),  64'(words[1]));

    // Asynchronous reset mid-word, between clock edges.
    words[2] = W'($urandom);
    send_partial(words[2], 5);
    check("pre_rst_cs", 64'(chip_select), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_cs",    64'(chip_select), 64'd1);
    check("arst_busy",  64'(busy),        64'd0);
    check("arst_valid", 64'(word_valid),  64'd0);
    check("arst_data",  64'(word_data),   64'd0);
    check("arst_level", 64'(fifo_level),  64'd0);
    check("arst_ovf",   64'(overflow),    64'd0);
    check("arst_fd",    64'(frame_done),  64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0; model_pos = 0; model_armed = 0; model_streaming = 0;
    tick();
    pulse_vid();
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    pulse_init();
    pulse_vid();
    words[3] = W'($urandom);
    send_word(words[3], 1'b0);
    check("post_rst_level", 64'(fifo_level), 64'(model_q.size()));
    check("post_rst_data",  64'(word_data),  64'(model_q[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
